// File: rtl/chain_k_sequencer_pkg.sv
// Shared constants, FSM state encoding and table-address packing for the
// matrix-chain k-loop sequencer.
package chain_pkg;

    localparam int N_MAX = 16;
    localparam int IDX_W = 5;
    localparam int DW    = 32;
    localparam int PW    = 8;
    localparam int AW    = 2 * IDX_W;

    localparam logic [DW-1:0]    COST_INF = 32'hFFFF_FFFF;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH0 = 3'd1,
        S_FETCH1 = 3'd2,
        S_ITER   = 3'd3,
        S_DRAIN1 = 3'd4,
        S_DRAIN2 = 3'd5,
        S_WRITE  = 3'd6
    } state_t;

    // Cost/split tables are addressed as {row, col}.
    function automatic logic [AW-1:0] tbl_addr(input logic [IDX_W-1:0] row,
                                               input logic [IDX_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/chain_k_sequencer_if.sv
// Request, memory-read, operand, result and write-back signals of the
// sequencer, bundled so the scheduler/datapath side connects in one place.
interface chain_k_sequencer_if;
    import chain_pkg::*;

    logic                start;
    logic [IDX_W-1:0]    i_in;
    logic [IDX_W-1:0]    j_in;
    logic                busy;
    logic                done;
    logic                err;

    logic [IDX_W-1:0]    p_raddr;
    logic [PW-1:0]       p_rdata;
    logic [AW-1:0]       ma_raddr;
    logic [DW-1:0]       ma_rdata;
    logic [AW-1:0]       mb_raddr;
    logic [DW-1:0]       mb_rdata;

    logic                op_clr;
    logic                op_valid;
    logic [PW-1:0]       op_pi;
    logic [PW-1:0]       op_pk;
    logic [PW-1:0]       op_pj;
    logic [DW-1:0]       op_mki;
    logic [DW-1:0]       op_mkj1;
    logic [DW-1:0]       op_kc;
    logic [DW-1:0]       min_in;
    logic [DW-1:0]       ko_in;

    logic                m_we;
    logic [AW-1:0]       m_waddr;
    logic [DW-1:0]       m_wdata;
    logic [IDX_W-1:0]    s_wdata;

    modport master (
        input  start, i_in, j_in,
        input  p_rdata, ma_rdata, mb_rdata,
        input  min_in, ko_in,
        output busy, done, err,
        output p_raddr, ma_raddr, mb_raddr,
        output op_clr, op_valid, op_pi, op_pk, op_pj, op_mki, op_mkj1, op_kc,
        output m_we, m_waddr, m_wdata, s_wdata
    );

    modport slave (
        output start, i_in, j_in,
        output p_rdata, ma_rdata, mb_rdata,
        output min_in, ko_in,
        input  busy, done, err,
        input  p_raddr, ma_raddr, mb_raddr,
        input  op_clr, op_valid, op_pi, op_pk, op_pj, op_mki, op_mkj1, op_kc,
        input  m_we, m_waddr, m_wdata, s_wdata
    );

endinterface

// File: rtl/chain_k_sequencer.sv
// Walks k = i..j-1 for one matrix-chain table entry, feeds operands to the
// computation stage and writes the resulting m[i][j]/s[i][j] back.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for start; validates (i,j)
//   S_FETCH0 | clear computation stage, read p[i-1]
//   S_FETCH1 | capture p[i-1], read p[j], k <= i
//   S_ITER   | issue reads for k; first cycle captures p[j]
//   S_DRAIN1 | last operand set is presented
//   S_DRAIN2 | computation stage registers the last operand set
//   S_WRITE  | write m[i][j], s[i][j]; done pulse
module chain_k_sequencer
    import chain_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    chain_k_sequencer_if.master  bus
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    i_q, i_d;
    logic [IDX_W-1:0]    j_q, j_d;
    logic [IDX_W-1:0]    k_q, k_d;
    logic [IDX_W-1:0]    kd_q, kd_d;
    logic                diag_q, diag_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic [PW-1:0]       pi_q, pi_d;
    logic [PW-1:0]       pj_q, pj_d;

    logic [PW-1:0]       hpi_q, hpi_d;
    logic [PW-1:0]       hpk_q, hpk_d;
    logic [PW-1:0]       hpj_q, hpj_d;
    logic [DW-1:0]       hmki_q, hmki_d;
    logic [DW-1:0]       hmkj1_q, hmkj1_d;
    logic [DW-1:0]       hkc_q, hkc_d;

    logic                illegal_req;
    logic [DW-1:0]       kc_live;
    logic                unused_ko;

    assign illegal_req = (bus.i_in == '0) || (bus.j_in == '0) ||
                         (bus.j_in > IDX_MAX) || (bus.i_in > bus.j_in);
    assign kc_live     = {{(DW-IDX_W){1'b0}}, kd_q};
    assign unused_ko   = ^bus.ko_in[DW-1:IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            kd_q    <= '0;
            diag_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            pi_q    <= '0;
            pj_q    <= '0;
            hpi_q   <= '0;
            hpk_q   <= '0;
            hpj_q   <= '0;
            hmki_q  <= '0;
            hmkj1_q <= '0;
            hkc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            kd_q    <= kd_d;
            diag_q  <= diag_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            pi_q    <= pi_d;
            pj_q    <= pj_d;
            hpi_q   <= hpi_d;
            hpk_q   <= hpk_d;
            hpj_q   <= hpj_d;
            hmki_q  <= hmki_d;
            hmkj1_q <= hmkj1_d;
            hkc_q   <= hkc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        kd_d    = kd_q;
        diag_d  = diag_q;
        err_d   = 1'b0;
        valid_d = (state_q == S_ITER);
        pi_d    = pi_q;
        pj_d    = pj_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d = bus.i_in;
                    j_d = bus.j_in;
                    if (illegal_req) begin
                        err_d = 1'b1;
                    end else if (bus.i_in == bus.j_in) begin
                        diag_d  = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        diag_d  = 1'b0;
                        state_d = S_FETCH0;
                    end
                end
            end
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: begin
                pi_d    = bus.p_rdata;
                k_d     = i_q;
                state_d = S_ITER;
            end
            S_ITER: begin
                // p[j] requested in FETCH1 lands during the first ITER cycle.
                if (k_q == i_q) begin
                    pj_d = bus.p_rdata;
                end
                kd_d = k_q;
                k_d  = k_q + IDX_ONE;
                if (k_q == j_q - IDX_ONE) begin
                    state_d = S_DRAIN1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_WRITE;
            S_WRITE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Operand outputs freeze on the last presented set between valid cycles.
    always_comb begin
        hpi_d   = hpi_q;
        hpk_d   = hpk_q;
        hpj_d   = hpj_q;
        hmki_d  = hmki_q;
        hmkj1_d = hmkj1_q;
        hkc_d   = hkc_q;
        if (valid_q) begin
            hpi_d   = pi_q;
            hpk_d   = bus.p_rdata;
            hpj_d   = pj_q;
            hmki_d  = bus.ma_rdata;
            hmkj1_d = bus.mb_rdata;
            hkc_d   = kc_live;
        end
    end

    assign bus.op_valid = valid_q;
    assign bus.op_pi    = valid_q ? pi_q         : hpi_q;
    assign bus.op_pk    = valid_q ? bus.p_rdata  : hpk_q;
    assign bus.op_pj    = valid_q ? pj_q         : hpj_q;
    assign bus.op_mki   = valid_q ? bus.ma_rdata : hmki_q;
    assign bus.op_mkj1  = valid_q ? bus.mb_rdata : hmkj1_q;
    assign bus.op_kc    = valid_q ? kc_live      : hkc_q;

    assign bus.busy = (state_q != S_IDLE);
    assign bus.err  = err_q;

    always_comb begin
        bus.p_raddr  = '0;
        bus.ma_raddr = '0;
        bus.mb_raddr = '0;
        bus.op_clr   = 1'b0;
        bus.m_we     = 1'b0;
        bus.done     = 1'b0;
        bus.m_waddr  = '0;
        bus.m_wdata  = '0;
        bus.s_wdata  = '0;
        case (state_q)
            S_FETCH0: begin
                bus.op_clr  = 1'b1;
                bus.p_raddr = i_q - IDX_ONE;
            end
            S_FETCH1: bus.p_raddr = j_q;
            S_ITER: begin
                bus.p_raddr  = k_q;
                bus.ma_raddr = tbl_addr(i_q, k_q);
                bus.mb_raddr = tbl_addr(k_q + IDX_ONE, j_q);
            end
            S_WRITE: begin
                bus.m_we    = 1'b1;
                bus.done    = 1'b1;
                bus.m_waddr = tbl_addr(i_q, j_q);
                bus.m_wdata = diag_q ? '0 : bus.min_in;
                bus.s_wdata = diag_q ? '0 : bus.ko_in[IDX_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chain_k_sequencer.sv
// Directed bench for chain_k_sequencer: behavioural memories, a model of the
// computation stage, and a scoreboard of expected write-backs.
module tb_chain_k_sequencer;
    import chain_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chain_k_sequencer_if bus();

    chain_k_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memories, one-cycle read latency, written back on m_we.
    logic [PW-1:0] p_mem [0:31];
    logic [DW-1:0] m_mem [0:1023];

    always @(posedge clk) begin
        bus.p_rdata  <= p_mem[bus.p_raddr];
        bus.ma_rdata <= m_mem[bus.ma_raddr];
        bus.mb_rdata <= m_mem[bus.mb_raddr];
        if (bus.m_we) m_mem[bus.m_waddr] <= bus.m_wdata;
    end

    // Computation stage: running minimum of m[i][k]+m[k+1][j]+p[i-1]p[k]p[j].
    logic [DW-1:0] cmin, cko, cost;
    always_comb cost = bus.op_mki + bus.op_mkj1 +
                       DW'(bus.op_pi) * DW'(bus.op_pk) * DW'(bus.op_pj);
    always @(posedge clk) begin
        if (rst || bus.op_clr) begin
            cmin <= COST_INF;
            cko  <= '0;
        end else if (bus.op_valid && cost < cmin) begin
            cmin <= cost;
            cko  <= bus.op_kc;
        end
    end
    assign bus.min_in = cmin;
    assign bus.ko_in  = cko;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [IDX_W-1:0] s;
        int               cyc;
    } exp_t;
    exp_t sb[$];

    // Monitor: each negedge belongs to the cycle ending at edge cyc+1.
    int we_cnt = 0, ov_cnt = 0, ov_first = 0, clr_cnt = 0, err_cnt = 0, err_cyc = 0;
    int kc_q[$];
    always @(negedge clk) begin
        exp_t e;
        if (bus.op_valid) begin
            if (ov_cnt == 0) ov_first = cyc + 1;
            ov_cnt++;
            kc_q.push_back(int'(bus.op_kc));
        end
        if (bus.op_clr) clr_cnt++;
        if (bus.err) begin
            err_cnt++;
            err_cyc = cyc + 1;
        end
        if (bus.m_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_m_we", 64'(bus.m_waddr), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                check("m_waddr", 64'(bus.m_waddr), 64'(e.addr));
                check("m_wdata", 64'(bus.m_wdata), 64'(e.data));
                check("s_wdata", 64'(bus.s_wdata), 64'(e.s));
                check("done_with_we", 64'(bus.done), 64'd1);
                check("done_cycle", 64'(cyc + 1), 64'(e.cyc));
            end
        end else if (bus.done) begin
            check("done_without_we", 64'(bus.done), 64'd0);
        end
    end

    task automatic clear_mon();
        ov_cnt = 0; ov_first = 0; clr_cnt = 0; err_cnt = 0; err_cyc = 0;
        kc_q.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic launch(input int i, input int j, input logic [DW-1:0] data,
                          input int s, output int t);
        exp_t e;
        @(negedge clk);
        clear_mon();
        t = cyc + 1;
        bus.start = 1'b1;
        bus.i_in  = IDX_W'(i);
        bus.j_in  = IDX_W'(j);
        e.addr = tbl_addr(IDX_W'(i), IDX_W'(j));
        e.data = data;
        e.s    = IDX_W'(s);
        e.cyc  = (i == j) ? t + 1 : t + (j - i) + 5;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(60);
    endtask

    task automatic launch_err(input int i, input int j);
        int t;
        int we0;
        @(negedge clk);
        clear_mon();
        we0 = we_cnt;
        t = cyc + 1;
        bus.start = 1'b1;
        bus.i_in  = IDX_W'(i);
        bus.j_in  = IDX_W'(j);
        @(negedge clk);
        bus.start = 1'b0;
        check("err_busy", 64'(bus.busy), 64'd0);
        repeat (4) @(negedge clk);
        check("err_count", 64'(err_cnt), 64'd1);
        check("err_cycle", 64'(err_cyc), 64'(t + 1));
        check("err_no_we", 64'(we_cnt), 64'(we0));
        check("err_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int we0;
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.i_in  = '0;
        bus.j_in  = '0;
        for (int a = 0; a < 32; a++) p_mem[a] = '0;
        for (int a = 0; a < 1024; a++) m_mem[a] = '0;
        p_mem[0] = 8'd10; p_mem[1] = 8'd20; p_mem[2] = 8'd30; p_mem[3] = 8'd40;
        m_mem[tbl_addr(5'd1, 5'd2)] = 32'd6000;
        m_mem[tbl_addr(5'd2, 5'd3)] = 32'd24000;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_m_we", 64'(bus.m_we), 64'd0);
        check("rst_op_valid", 64'(bus.op_valid), 64'd0);
        check("rst_op_clr", 64'(bus.op_clr), 64'd0);
        check("rst_p_raddr", 64'(bus.p_raddr), 64'd0);
        check("rst_op_mki", 64'(bus.op_mki), 64'd0);
        rst = 1'b0;

        // (1,3): two k iterations, minimum at k=2.
        launch(1, 3, 32'd18000, 2, t);
        check("13_ov_cnt", 64'(ov_cnt), 64'd2);
        check("13_ov_first", 64'(ov_first), 64'(t + 4));
        check("13_kc_cnt", 64'(kc_q.size()), 64'd2);
        if (kc_q.size() == 2) begin
            check("13_kc0", 64'(kc_q[0]), 64'd1);
            check("13_kc1", 64'(kc_q[1]), 64'd2);
        end
        check("13_clr_cnt", 64'(clr_cnt), 64'd1);

        // (1,2): single iteration.
        launch(1, 2, 32'd6000, 1, t);
        check("12_ov_cnt", 64'(ov_cnt), 64'd1);
        check("12_ov_first", 64'(ov_first), 64'(t + 4));

        // (2,2): diagonal entry, straight to write.
        launch(2, 2, 32'd0, 0, t);
        check("22_ov_cnt", 64'(ov_cnt), 64'd0);
        check("22_clr_cnt", 64'(clr_cnt), 64'd0);

        launch_err(3, 1);
        launch_err(0, 2);
        launch_err(1, 17);

        // Reset during ITER abandons the entry.
        @(negedge clk);
        clear_mon();
        we0 = we_cnt;
        t = cyc + 1;
        bus.start = 1'b1;
        bus.i_in  = 5'd1;
        bus.j_in  = 5'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_op_valid", 64'(bus.op_valid), 64'd0);
        check("mid_rst_op_pk", 64'(bus.op_pk), 64'd0);
        check("mid_rst_op_pi", 64'(bus.op_pi), 64'd0);
        check("mid_rst_op_mki", 64'(bus.op_mki), 64'd0);
        check("mid_rst_op_kc", 64'(bus.op_kc), 64'd0);
        check("mid_rst_p_raddr", 64'(bus.p_raddr), 64'd0);
        check("mid_rst_ma_raddr", 64'(bus.ma_raddr), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_rst_no_we", 64'(we_cnt), 64'(we0));
        launch(1, 3, 32'd18000, 2, t);

        // start held high: second run begins in the IDLE cycle after WRITE.
        @(negedge clk);
        clear_mon();
        we0 = we_cnt;
        t = cyc + 1;
        bus.start = 1'b1;
        bus.i_in  = 5'd1;
        bus.j_in  = 5'd3;
        e.addr = tbl_addr(5'd1, 5'd3);
        e.data = 32'd18000;
        e.s    = 5'd2;
        e.cyc  = t + 7;
        sb.push_back(e);
        e.cyc  = t + 15;
        sb.push_back(e);
        repeat (9) @(negedge clk);
        bus.start = 1'b0;
        wait_drain(60);
        check("held_we_cnt", 64'(we_cnt - we0), 64'd2);
        check("held_ov_cnt", 64'(ov_cnt), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
